// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-fed UART transmitter.
package gpio_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered count and a registered, first-word-fall-through read port.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [7:0]    rd_data_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == DEPTH[AW:0]);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Head word is prefetched; bypass the write when it lands on the next head slot.
      if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/gpio_uart_tx.sv
// Buffers GPIO byte writes and sends them as UART frames (8N1, or 8E1 when
// GPIO_UART_PARITY_EN is defined).
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    gpio_data,
  input  logic                          gpio_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  tx_state_t     state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          overflow_reg;
`ifdef GPIO_UART_PARITY_EN
  logic          parity_reg;
`endif

  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       baud_done;
  logic       push;
  logic       pop;

  assign baud_done = (baud_cnt_reg == '0);
  assign push      = gpio_en && !fifo_full;
  assign pop       = !fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_done));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (gpio_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx       = tx_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
`ifdef GPIO_UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      if (gpio_en && fifo_full) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg    <= fifo_rd_data;
`ifdef GPIO_UART_PARITY_EN
            parity_reg   <= ^fifo_rd_data;
`endif
            baud_cnt_reg <= BAUD_LAST;
            tx_reg       <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt_reg <= BAUD_LAST;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= BAUD_LAST;
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef GPIO_UART_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
`ifdef GPIO_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt_reg <= BAUD_LAST;
            tx_reg       <= 1'b1;
            state_reg    <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            // Chain straight into the next start bit so queued bytes go out with no idle gap.
            if (pop) begin
              shift_reg    <= fifo_rd_data;
`ifdef GPIO_UART_PARITY_EN
              parity_reg   <= ^fifo_rd_data;
`endif
              baud_cnt_reg <= BAUD_LAST;
              tx_reg       <= 1'b0;
              state_reg    <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Scoreboard bench for gpio_uart_tx: a frame-level reference model predicts every cycle,
// and an independent line monitor decodes frames from tx against the expected-byte queue.
module tb_gpio_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef GPIO_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR        = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR        = 1'b0;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gpio_en = 1'b0;
  logic [7:0] gpio_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;

  gpio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_data  (gpio_data),
    .gpio_en    (gpio_en),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: bytes waiting, cycles left in the frame on the line, sticky overflow.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_rem = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_cur = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_tx();
    int p;
    int b;
    if (m_rem == 0) return 1'b1;
    p = FRAME_CYC - m_rem;
    b = p / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (PAR && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  task automatic step(input logic en, input logic [7:0] d, input logic r);
    bit full;
    bit pop;
    gpio_en   = en;
    gpio_data = d;
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      exp_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() > 0) && (m_rem <= 1);
      if (pop) begin
        m_cur = m_q.pop_front();
        m_rem = FRAME_CYC;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (en) begin
        if (full) m_ovf = 1'b1;
        else begin
          m_q.push_back(d);
          exp_q.push_back(d);
        end
      end
    end
    #1;
    chk("tx", {31'd0, tx}, {31'd0, model_tx()});
    chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0) || (m_q.size() != 0)});
    chk("fifo_count", {29'd0, fifo_count}, m_q.size());
    chk("fifo_full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Line monitor: decodes frames from tx alone and pops the scoreboard.
  initial begin
    bit         active = 1'b0;
    bit         prev_tx = 1'b1;
    int         p = 0;
    logic [FRAME_BITS-1:0] bits = '0;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst) begin
        active  = 1'b0;
        prev_tx = 1'b1;
        continue;
      end
      if (!active && prev_tx && !tx) begin
        active = 1'b1;
        p      = 0;
      end
      if (active) begin
        if (p % CLK_DIV == CLK_DIV / 2) bits[p / CLK_DIV] = tx;
        p++;
        if (p == FRAME_CYC) begin
          active = 1'b0;
          chk("start_bit", {31'd0, bits[0]}, 32'd0);
          chk("stop_bit", {31'd0, bits[FRAME_BITS-1]}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, want});
            if (PAR) chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^want});
          end
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    int n;
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Single byte
    step(1'b1, 8'hA5, 1'b0);
    idle(45);

    // Three back-to-back bytes
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    idle(125);

    // Six writes: last one dropped, overflow sticky
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    idle(5 * FRAME_CYC + 10);

    // Reset in the middle of a data bit, then a clean frame
    step(1'b1, 8'hFF, 1'b0);
    idle(15);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    idle(FRAME_CYC + 5);

    // Full FIFO with a write on the cycle the stop bit ends and pops
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    n = 0;
    while (m_rem != 1 && n < 200) begin
      idle(1);
      n++;
    end
    chk("stop_end_wait", n < 200, 32'd1);
    step(1'b1, 8'h5A, 1'b0);
    chk("drop_on_pop_count", {29'd0, fifo_count}, 32'd3);
    idle(4 * FRAME_CYC + 10);

    // Random traffic
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) == 0, 8'($urandom_range(0, 255)), 1'b0);
    n = 0;
    while ((m_rem != 0 || m_q.size() != 0) && n < 1000) begin
      idle(1);
      n++;
    end
    chk("drain_wait", n < 1000, 32'd1);
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
